// File: rtl/ysyx_22040365_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
// Holds the FSM states, halt reason codes and the special instruction encodings.
package ysyx_22040365_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET_IDLE = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_WB         = 3'd4,
    S_HALT       = 3'd5
  } state_t;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;
  localparam logic [1:0] HALT_ILLEGAL = 2'd3;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22040365_fetch_timer.sv
// Saturating 8-bit count of stalled fetch cycles; expired is combinational from the count.
// expired flags the stalled cycle that uses up the budget, so a valid in that same cycle still wins.
module ysyx_22040365_fetch_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The count is checked before it increments: with LIMIT stalls the last one sees LIMIT-1.
  assign expired = (cnt >= (LIMIT - 8'd1));

endmodule

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle sequencer: owns the PC and steps each instruction through FETCH, DECODE, EXEC and WB.
// Best case is 4 cycles per instruction; fetch waits on if_rvalid and halts after a bounded stall.
module ysyx_22040365_ctrl
  import ysyx_22040365_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  input  logic        id_illegal,
  input  logic        ex_wen,
  output logic        rf_wen,
  output logic [63:0] pc,
  output logic [63:0] retired,
  output logic        halt,
  output logic [1:0]  halt_code
);

  state_t state;
  logic   expired;
  logic   in_fetch;

  assign in_fetch = (state == S_FETCH);

  ysyx_22040365_fetch_timer #(
    .LIMIT (8'(FETCH_TIMEOUT))
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_fetch || if_rvalid),
    .inc     (in_fetch && !if_rvalid),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RESET_IDLE;
      pc        <= RESET_PC;
      inst      <= INST_NOP;
      retired   <= 64'd0;
      halt      <= 1'b0;
      halt_code <= HALT_NONE;
    end else begin
      case (state)
        S_RESET_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (if_rvalid) begin
            inst  <= if_rdata;
            state <= S_DECODE;
          end else if (expired) begin
            state     <= S_HALT;
            halt      <= 1'b1;
            halt_code <= HALT_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (id_illegal) begin
            state     <= S_HALT;
            halt      <= 1'b1;
            halt_code <= HALT_ILLEGAL;
          end else if (inst == INST_EBREAK) begin
            // ebreak retires but leaves the PC pointing at itself.
            retired   <= retired + 64'd1;
            state     <= S_HALT;
            halt      <= 1'b1;
            halt_code <= HALT_EBREAK;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          pc      <= pc + 64'd4;
          retired <= retired + 64'd1;
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  assign if_req  = in_fetch;
  assign if_addr = pc;
  assign rf_wen  = (state == S_WB) && ex_wen;

endmodule
